// File: rtl/tree_node_walker.sv
// -----------------------------------------------------------------------------
// tree_node_walker
//
// Walks a decision tree held in an external node RAM. Starting at a root
// address, each internal node requests one MAC accumulation. The returned
// value is compared (unsigned) against the node threshold to pick the next
// child. A leaf ends the walk and reports its class label. A walk that
// evaluates MAX_DEPTH internal nodes without reaching a leaf ends with error.
//
// Node word layout, MSB to LSB:
//   is_leaf[1] | threshold[ACC_WIDTH] | left[NODE_ADDR_WIDTH] |
//   right[NODE_ADDR_WIDTH] | class[CLASS_WIDTH]
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin a walk (sampled only while idle)
//   root_addr    first node address, sampled with start
//   node_rd      node RAM read strobe; node_data is valid the next cycle
//   node_addr    node RAM address
//   node_data    node RAM read data
//   mac_start    one-cycle MAC request
//   mac_node     node whose coefficients the MAC uses, held until response
//   acc_in       MAC result, sampled only with acc_valid while waiting
//   acc_valid    MAC result strobe
//   busy         walk in progress
//   done         one-cycle completion pulse
//   error        depth limit reached (held until next start)
//   class_out    leaf class (held until next start)
//   depth_out    internal nodes traversed (held until next start)
// -----------------------------------------------------------------------------
module tree_node_walker #(
  parameter int ACC_WIDTH       = 20,
  parameter int NODE_ADDR_WIDTH = 8,
  parameter int CLASS_WIDTH     = 4,
  parameter int MAX_DEPTH       = 16,
  localparam int NODE_W = 1 + ACC_WIDTH + 2 * NODE_ADDR_WIDTH + CLASS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NODE_ADDR_WIDTH-1:0] root_addr,
  output logic                       node_rd,
  output logic [NODE_ADDR_WIDTH-1:0] node_addr,
  input  logic [NODE_W-1:0]          node_data,
  output logic                       mac_start,
  output logic [NODE_ADDR_WIDTH-1:0] mac_node,
  input  logic [ACC_WIDTH-1:0]       acc_in,
  input  logic                       acc_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [CLASS_WIDTH-1:0]     class_out,
  output logic [4:0]                 depth_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_MREQ,
    S_MWAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NODE_ADDR_WIDTH-1:0] r_cur;
  logic [4:0]                 r_depth;
  logic [ACC_WIDTH-1:0]       r_thr;
  logic [NODE_ADDR_WIDTH-1:0] r_left;
  logic [NODE_ADDR_WIDTH-1:0] r_right;
  logic                       r_error;
  logic [CLASS_WIDTH-1:0]     r_class;

  // Node word field extraction.
  logic                       w_is_leaf;
  logic [ACC_WIDTH-1:0]       w_thr;
  logic [NODE_ADDR_WIDTH-1:0] w_left;
  logic [NODE_ADDR_WIDTH-1:0] w_right;
  logic [CLASS_WIDTH-1:0]     w_class;
  logic                       w_depth_hit;

  assign w_is_leaf   = node_data[NODE_W-1];
  assign w_thr       = node_data[NODE_W-2 -: ACC_WIDTH];
  assign w_left      = node_data[2*NODE_ADDR_WIDTH+CLASS_WIDTH-1 -: NODE_ADDR_WIDTH];
  assign w_right     = node_data[NODE_ADDR_WIDTH+CLASS_WIDTH-1 -: NODE_ADDR_WIDTH];
  assign w_class     = node_data[CLASS_WIDTH-1:0];
  assign w_depth_hit = (r_depth == 5'(MAX_DEPTH));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and Moore outputs. Strobes are decoded from the state, so
  // node_rd (FETCH) and mac_start (MREQ) can never coincide.
  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    node_rd   = 1'b0;
    node_addr = '0;
    mac_start = 1'b0;
    mac_node  = '0;
    done      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        node_rd   = 1'b1;
        node_addr = r_cur;
        w_next    = S_LATCH;
      end
      S_LATCH: begin
        if (w_is_leaf || w_depth_hit) w_next = S_DONE;
        else                          w_next = S_MREQ;
      end
      S_MREQ: begin
        mac_start = 1'b1;
        mac_node  = r_cur;
        w_next    = S_MWAIT;
      end
      S_MWAIT: begin
        mac_node = r_cur;
        if (acc_valid) w_next = S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Walk datapath: current node, depth, latched node fields and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur   <= '0;
      r_depth <= '0;
      r_thr   <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_error <= 1'b0;
      r_class <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur   <= root_addr;
            r_depth <= '0;
            r_error <= 1'b0;
            r_class <= '0;
          end
        end
        S_LATCH: begin
          r_thr   <= w_thr;
          r_left  <= w_left;
          r_right <= w_right;
          if (w_is_leaf) begin
            r_class <= w_class;
          end else if (w_depth_hit) begin
            r_error <= 1'b1;
            r_class <= '0;
          end
        end
        S_MWAIT: begin
          if (acc_valid) begin
            // Unsigned compare; equality goes right.
            r_cur   <= (acc_in >= r_thr) ? r_right : r_left;
            r_depth <= r_depth + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign error     = r_error;
  assign class_out = r_class;
  assign depth_out = r_depth;

endmodule

// File: tb/tb_tree_node_walker.sv
module tb_tree_node_walker;

  localparam int AW = 20;
  localparam int NA = 8;
  localparam int CW = 4;
  localparam int NW = 1 + AW + 2 * NA + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NA-1:0] root_addr = '0;
  logic          node_rd;
  logic [NA-1:0] node_addr;
  logic [NW-1:0] node_data = '0;
  logic          mac_start;
  logic [NA-1:0] mac_node;
  logic [AW-1:0] acc_in = '0;
  logic          acc_valid = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] class_out;
  logic [4:0]    depth_out;

  int total = 0;
  int bad   = 0;

  int mac_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  logic [NW-1:0] mem [0:255];

  tree_node_walker dut (
    .clk(clk), .rst(rst), .start(start), .root_addr(root_addr),
    .node_rd(node_rd), .node_addr(node_addr), .node_data(node_data),
    .mac_start(mac_start), .mac_node(mac_node), .acc_in(acc_in),
    .acc_valid(acc_valid), .busy(busy), .done(done), .error(error),
    .class_out(class_out), .depth_out(depth_out)
  );

  always #5 clk = ~clk;

  // Node RAM model: one-cycle read latency.
  always @(posedge clk) if (node_rd) node_data <= mem[node_addr];

  // Passive monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (mac_start === 1'b1) mac_cnt++;
    if (done === 1'b1) done_cnt++;
    if (node_rd === 1'b1 && mac_start === 1'b1) overlap_cnt++;
  end

  function automatic logic [NW-1:0] mk_node(input logic leaf, input logic [AW-1:0] thr,
                                            input logic [NA-1:0] l, input logic [NA-1:0] r,
                                            input logic [CW-1:0] c);
    return {leaf, thr, l, r, c};
  endfunction

  // Returns mid-cycle of FETCH (cycle t+1 after accepting edge t).
  task automatic do_start(input logic [NA-1:0] a);
    @(negedge clk);
    start = 1'b1;
    root_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the mid-cycle where mac_start is high.
  task automatic wait_mac(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mac_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s_mac_timeout got=no mac_start exp=mac_start", tag); end
  endtask

  // Called mid-MREQ; acc_valid lands in MWAIT cycle number 'w'.
  task automatic respond(input int w, input logic [AW-1:0] val);
    repeat (w) @(negedge clk);
    acc_valid = 1'b1;
    acc_in = val;
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s_done_timeout got=no done exp=done", tag); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, error, node_rd, mac_start} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, error, node_rd, mac_start});
    end
    total++;
    if ({class_out, depth_out, node_addr, mac_node} !== '0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {class_out, depth_out, node_addr, mac_node});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_root_leaf;
    int m0 = mac_cnt;
    do_start(8'd5);
    total++;
    if (node_rd !== 1'b1 || node_addr !== 8'd5 || busy !== 1'b1) begin
      bad++; $display("FAIL leaf_fetch got=rd%b addr%0d busy%b exp=rd1 addr5 busy1", node_rd, node_addr, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL leaf_early_done got=%b exp=0", done); end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || class_out !== 4'd9 || error !== 1'b0 || depth_out !== 5'd0) begin
      bad++; $display("FAIL leaf_done got=done%b cls%0d err%b dep%0d exp=done1 cls9 err0 dep0",
                      done, class_out, error, depth_out);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || mac_cnt != m0) begin
      bad++; $display("FAIL leaf_after got=busy%b done%b macs%0d exp=busy0 done0 macs0", busy, done, mac_cnt - m0);
    end
  endtask

  task automatic test_two_level;
    logic [AW-1:0] vals [3];
    logic [CW-1:0] exp_cls [3];
    vals[0] = 20'h003FF; exp_cls[0] = 4'd2;
    vals[1] = 20'h00400; exp_cls[1] = 4'd7;
    vals[2] = 20'hFFFFF; exp_cls[2] = 4'd7;
    for (int k = 0; k < 3; k++) begin
      do_start(8'd0);
      wait_mac("two_level");
      total++;
      if (mac_node !== 8'd0) begin bad++; $display("FAIL two_level_mac_node got=%0d exp=0", mac_node); end
      respond(1, vals[k]);
      wait_done("two_level");
      total++;
      if (class_out !== exp_cls[k] || depth_out !== 5'd1 || error !== 1'b0) begin
        bad++; $display("FAIL two_level_%0d got=cls%0d dep%0d err%b exp=cls%0d dep1 err0",
                        k, class_out, depth_out, error, exp_cls[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_latency(input int w);
    int m0 = mac_cnt;
    do_start(8'd0);
    repeat (2) @(negedge clk);
    total++;
    if (mac_start !== 1'b1 || mac_node !== 8'd0) begin
      bad++; $display("FAIL lat%0d_mreq got=ms%b node%0d exp=ms1 node0", w, mac_start, mac_node);
    end
    @(negedge clk);
    total++;
    if (mac_start !== 1'b0 || busy !== 1'b1 || mac_node !== 8'd0) begin
      bad++; $display("FAIL lat%0d_mwait got=ms%b busy%b node%0d exp=ms0 busy1 node0", w, mac_start, busy, mac_node);
    end
    repeat (w - 1) @(negedge clk);
    acc_valid = 1'b1;
    acc_in = 20'hFFFFF;
    @(negedge clk);
    acc_valid = 1'b0;
    total++;
    if (node_rd !== 1'b1 || node_addr !== 8'd2) begin
      bad++; $display("FAIL lat%0d_refetch got=rd%b addr%0d exp=rd1 addr2", w, node_rd, node_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b1 || class_out !== 4'd7 || mac_cnt - m0 != 1) begin
      bad++; $display("FAIL lat%0d_done got=done%b cls%0d macs%0d exp=done1 cls7 macs1", w, done, class_out, mac_cnt - m0);
    end
    @(negedge clk);
  endtask

  task automatic test_depth_limit;
    int m0 = mac_cnt;
    do_start(8'd3);
    for (int i = 0; i < 16; i++) begin
      wait_mac("depth");
      respond(1, 20'h00000);
    end
    wait_done("depth");
    total++;
    if (error !== 1'b1 || class_out !== 4'd0 || depth_out !== 5'd16) begin
      bad++; $display("FAIL depth_result got=err%b cls%0d dep%0d exp=err1 cls0 dep16", error, class_out, depth_out);
    end
    total++;
    if (mac_cnt - m0 != 16) begin bad++; $display("FAIL depth_mac_count got=%0d exp=16", mac_cnt - m0); end
    @(negedge clk);
  endtask

  task automatic test_abuse;
    int m0 = mac_cnt;
    acc_valid = 1'b1; acc_in = 20'hFFFFF;
    @(negedge clk);
    acc_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abuse_idle_acc got=busy%b exp=busy0", busy); end
    do_start(8'd0);
    acc_valid = 1'b1; acc_in = 20'hFFFFF;
    @(negedge clk);
    acc_valid = 1'b0;
    wait_mac("abuse");
    @(negedge clk);
    start = 1'b1; root_addr = 8'd5;
    @(negedge clk);
    start = 1'b0;
    acc_valid = 1'b1; acc_in = 20'h003FF;
    @(negedge clk);
    acc_valid = 1'b0;
    total++;
    if (node_addr !== 8'd1 || node_rd !== 1'b1) begin
      bad++; $display("FAIL abuse_next got=rd%b addr%0d exp=rd1 addr1", node_rd, node_addr);
    end
    wait_done("abuse");
    total++;
    if (class_out !== 4'd2 || depth_out !== 5'd1 || error !== 1'b0 || mac_cnt - m0 != 1) begin
      bad++; $display("FAIL abuse_result got=cls%0d dep%0d err%b macs%0d exp=cls2 dep1 err0 macs1",
                      class_out, depth_out, error, mac_cnt - m0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_start(8'd0);
    wait_mac("b2b");
    respond(1, 20'h00000);
    wait_done("b2b");
    start = 1'b1; root_addr = 8'd5;   // arrives during DONE: ignored
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start got=busy%b exp=busy0", busy); end
    @(negedge clk);                   // held into IDLE: accepted
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || node_addr !== 8'd5) begin
      bad++; $display("FAIL b2b_accept got=busy%b addr%0d exp=busy1 addr5", busy, node_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b1 || class_out !== 4'd9 || depth_out !== 5'd0) begin
      bad++; $display("FAIL b2b_done got=done%b cls%0d dep%0d exp=done1 cls9 dep0", done, class_out, depth_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int d0;
    do_start(8'd0);
    wait_mac("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    total++;
    if ({busy, done, error, node_rd, mac_start, class_out, depth_out, node_addr, mac_node} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=0",
                      {busy, done, error, node_rd, mac_start, class_out, depth_out, node_addr, mac_node});
    end
    acc_valid = 1'b1; acc_in = 20'hFFFFF;
    @(negedge clk);
    acc_valid = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_quiet got=dones%0d busy%b exp=dones0 busy0", done_cnt - d0, busy);
    end
    do_start(8'd0);
    wait_mac("rst_mid_new");
    respond(3, 20'h00000);
    wait_done("rst_mid_new");
    total++;
    if (class_out !== 4'd2 || depth_out !== 5'd1 || error !== 1'b0) begin
      bad++; $display("FAIL rst_mid_new got=cls%0d dep%0d err%b exp=cls2 dep1 err0", class_out, depth_out, error);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = mk_node(1'b0, 20'h00400, 8'd1, 8'd2, 4'd0);
    mem[1] = mk_node(1'b1, 20'h0, 8'd0, 8'd0, 4'd2);
    mem[2] = mk_node(1'b1, 20'h0, 8'd0, 8'd0, 4'd7);
    mem[3] = mk_node(1'b0, 20'h00001, 8'd3, 8'd3, 4'd0);
    mem[5] = mk_node(1'b1, 20'hABCDE, 8'd7, 8'd8, 4'd9);

    test_reset();
    test_root_leaf();
    test_two_level();
    test_latency(1);
    test_latency(10);
    test_depth_limit();
    test_abuse();
    test_back_to_back();
    test_reset_mid();

    total++;
    if (overlap_cnt != 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
